risc_v_pipelined_core: RTL and testbench
========================================

# risc_v_pipelined_core

Five-stage pipelined RV32I-subset core (IF, ID, EX, MEM, WB). It is the next generation of the team's single-cycle add/addi processor. It adds loads, stores, logic ops, branches, jal and lui, with hazard detection, optional operand forwarding and branch flushing. Instruction and data memories sit outside the block, so benches and the SoC top supply them. A retire port exposes every completed instruction for checking.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr_o  out  32  current IF PC; byte address.
- imem_data_i  in  32  instruction at imem_addr_o; combinational, same cycle.
- dmem_addr_o  out  32  ALU result of the instruction in MEM.
- dmem_wdata_o  out  32  store data (rs2) of the instruction in MEM.
- dmem_we_o  out  1  sw in MEM; memory writes on the clock edge.
- dmem_re_o  out  1  lw in MEM.
- dmem_rdata_i  in  32  load data; combinational, same cycle.
- retire_valid_o  out  1  a non-bubble instruction is in WB.
- retire_pc_o  out  32  PC of the WB instruction.
- retire_we_o  out  1  register write performed; 0 when rd=x0.
- retire_rd_o  out  5  destination register.
- retire_wdata_o  out  32  value written.
- stall_o  out  1  PC and IF/ID held this cycle.
- flush_o  out  1  redirect this cycle; IF/ID and ID/EX squashed.

## Operation
- Supported instructions: add, sub, and, or, slt, addi, andi, ori, lw, sw, beq, bne, jal, lui.
  - Any other opcode executes as a NOP: no register or memory write.
  - It still retires, with retire_we_o=0.
- Register file: 32x32.
  - x0 reads 0; writes to x0 are dropped.
  - WB writes on the edge.
  - ID reads bypass a same-cycle WB write (write-before-read).
- Pipeline registers carry a valid bit; a bubble has valid=0 and all write enables clear.
- Load-use hazard: lw in EX whose rd≠0 matches a used rs1/rs2 of the ID instruction.
  - Response: stall_o=1 for 1 cycle, PC and IF/ID hold, a bubble is inserted into ID/EX.
- Branches and jal resolve in EX.
  - On taken beq/bne or any jal: next PC = EX PC + imm and flush_o=1.
  - The two younger instructions become bubbles; penalty is 2 cycles.
  - jal writes EX PC + 4 to rd.
- Priority: flush over stall. A stall request in the same cycle as a flush is discarded.
- Arithmetic: 32-bit, wrap-around, no overflow traps. slt is signed. Immediates are sign-extended per format. lui places imm[31:12] and zeroes the low 12 bits.
- Misaligned addresses are not checked; the low two bits pass through unchanged.

## Timing
- An instruction fetched in cycle n retires in cycle n+4 when no stall or flush occurs.
- CPI is 1 in steady state.
- During reset (reset=0), asynchronously:
  - PC=RESET_PC and imem_addr_o=RESET_PC.
  - All valid bits are 0 and the register file is all zero.
  - Every output other than imem_addr_o is 0: dmem_*, retire_*, stall_o, flush_o.
- First fetch happens in the first cycle after reset rises. The first retire_valid_o=1 comes 4 cycles later.
- Asserting reset mid-operation drops all in-flight instructions immediately. No dmem write occurs in that cycle.
- retire_* and dmem_* are driven directly from the MEM/WB and EX/MEM registers, with no extra latency.

## Configuration
- FORWARDING_EN defined:
  - EX operands come from EX/MEM (priority) or MEM/WB when rd≠0 matches.
  - The only stall is load-use, 1 cycle.
- FORWARDING_EN undefined:
  - No forwarding paths.
  - ID stalls while a used rs≠0 matches the rd of a writing instruction in EX or MEM: 2 stall cycles for an adjacent dependency, 1 cycle for a gap of one.
  - Load-use is covered by the same rule.
  - Architectural results are identical in both builds; only cycle counts differ.

## Test plan
- **Reset.** Hold reset=0 for 3 cycles, then release.
  - During reset: imem_addr_o=0x0040_0000, retire_valid_o=0, dmem_we_o=0.
  - First retire occurs 4 cycles after release, with retire_pc_o=0x0040_0000.
- **Adjacent dependency.** Run addi x1,x0,5 then add x2,x1,x1.
  - x2 retires with wdata=10.
  - With FORWARDING_EN it retires 1 cycle after x1, with no stall.
  - Without FORWARDING_EN it retires 3 cycles after x1, with stall_o high for 2 cycles.
- **Load-use.** Run addi x1,x0,7; sw x1,8(x0); lw x3,8(x0); add x4,x3,x3.
  - dmem_we_o is high for 1 cycle with addr=8 and wdata=7.
  - stall_o=1 for exactly 1 cycle in the forwarding build.
  - x4 retires with value 14.
- **Branch flush.** Run beq x0,x0,+12 followed by two addi.
  - flush_o=1 for 1 cycle.
  - Neither addi retires.
  - The next retire_pc_o is the branch PC + 12.
  - The not-taken case (bne x0,x0) gives no flush and sequential retire.
- **x0 and jal.** Run addi x0,x0,9, add x5,x0,x0, then jal x6,+8 at PC P.
  - addi x0 retires with retire_we_o=0.
  - x5 retires with value 0.
  - x6 retires with value P+4, followed by 2 squashed slots.
- **Reset mid-flight.** Drop reset while a sw is in MEM.
  - dmem_we_o goes to 0 immediately.
  - x-registers read 0 afterwards.
  - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/risc_v_pipelined_core.sv
// Five-stage RV32I-subset pipeline (IF/ID/EX/MEM/WB) with hazard stalls and branch flushing.
// Define FORWARDING_EN to add EX operand forwarding; otherwise ID stalls until producers reach WB.
module risc_v_pipelined_core #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic        dmem_we_o,
   output logic        dmem_re_o,
   input  logic [31:0] dmem_rdata_i,
   output logic        retire_valid_o,
   output logic [31:0] retire_pc_o,
   output logic        retire_we_o,
   output logic [4:0]  retire_rd_o,
   output logic [31:0] retire_wdata_o,
   output logic        stall_o,
   output logic        flush_o
);

   typedef enum logic [3:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_ANDI,
      OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_LUI
   } op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      op_e         op;
      logic [4:0]  rd;
      logic        we;
`ifdef FORWARDING_EN
      logic [4:0]  rs1;
      logic [4:0]  rs2;
`endif
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
   } id_ex_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        we;
      logic        re;
      logic        st;
      logic [31:0] result;
      logic [31:0] sdata;
   } ex_mem_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] wdata;
   } mem_wb_t;

   logic [31:0] pc_q;
   if_id_t      if_id_q;
   id_ex_t      id_ex_q;
   ex_mem_t     ex_mem_q;
   mem_wb_t     mem_wb_q;
   logic [31:0] regs [32];

   // ---------------- ID: decode ----------------
   logic [6:0]  id_opcode, id_funct7;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   op_e         id_op;
   logic [31:0] id_imm, id_a, id_b;
   logic        id_use1, id_use2, id_writes;
   logic        rf_we, stall_req;

   assign id_opcode = if_id_q.instr[6:0];
   assign id_rd     = if_id_q.instr[11:7];
   assign id_funct3 = if_id_q.instr[14:12];
   assign id_rs1    = if_id_q.instr[19:15];
   assign id_rs2    = if_id_q.instr[24:20];
   assign id_funct7 = if_id_q.instr[31:25];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      id_op = OP_NOP;
      case (id_opcode)
         7'b0110011: begin
            if (id_funct7 == 7'b0000000) begin
               case (id_funct3)
                  3'b000:  id_op = OP_ADD;
                  3'b111:  id_op = OP_AND;
                  3'b110:  id_op = OP_OR;
                  3'b010:  id_op = OP_SLT;
                  default: id_op = OP_NOP;
               endcase
            end else if (id_funct7 == 7'b0100000 && id_funct3 == 3'b000) begin
               id_op = OP_SUB;
            end
         end
         7'b0010011: begin
            case (id_funct3)
               3'b000:  id_op = OP_ADDI;
               3'b111:  id_op = OP_ANDI;
               3'b110:  id_op = OP_ORI;
               default: id_op = OP_NOP;
            endcase
         end
         7'b0000011: if (id_funct3 == 3'b010) id_op = OP_LW;
         7'b0100011: if (id_funct3 == 3'b010) id_op = OP_SW;
         7'b1100011: begin
            if (id_funct3 == 3'b000)      id_op = OP_BEQ;
            else if (id_funct3 == 3'b001) id_op = OP_BNE;
         end
         7'b1101111: id_op = OP_JAL;
         7'b0110111: id_op = OP_LUI;
         default:    id_op = OP_NOP;
      endcase
   end

   always_comb begin
      id_imm    = '0;
      id_use1   = 1'b0;
      id_use2   = 1'b0;
      id_writes = 1'b0;
      case (id_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
            id_use1 = 1'b1; id_use2 = 1'b1; id_writes = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
            id_use1 = 1'b1; id_writes = 1'b1;
            id_imm  = {{20{if_id_q.instr[31]}}, if_id_q.instr[31:20]};
         end
         OP_SW: begin
            id_use1 = 1'b1; id_use2 = 1'b1;
            id_imm  = {{20{if_id_q.instr[31]}}, if_id_q.instr[31:25], if_id_q.instr[11:7]};
         end
         OP_BEQ, OP_BNE: begin
            id_use1 = 1'b1; id_use2 = 1'b1;
            id_imm  = {{19{if_id_q.instr[31]}}, if_id_q.instr[31], if_id_q.instr[7],
                       if_id_q.instr[30:25], if_id_q.instr[11:8], 1'b0};
         end
         OP_JAL: begin
            id_writes = 1'b1;
            id_imm    = {{11{if_id_q.instr[31]}}, if_id_q.instr[31], if_id_q.instr[19:12],
                         if_id_q.instr[20], if_id_q.instr[30:21], 1'b0};
         end
         OP_LUI: begin
            id_writes = 1'b1;
            id_imm    = {if_id_q.instr[31:12], 12'h000};
         end
         default: ;
      endcase
      id_use1 = id_use1 & if_id_q.valid;
      id_use2 = id_use2 & if_id_q.valid;
   end

   // Register reads see a WB write landing on the same edge.
   assign rf_we = mem_wb_q.valid & mem_wb_q.we;
   assign id_a  = (id_rs1 == 5'd0) ? 32'd0 :
                  (rf_we && mem_wb_q.rd == id_rs1) ? mem_wb_q.wdata : regs[id_rs1];
   assign id_b  = (id_rs2 == 5'd0) ? 32'd0 :
                  (rf_we && mem_wb_q.rd == id_rs2) ? mem_wb_q.wdata : regs[id_rs2];

   // ---------------- hazard detection ----------------
`ifdef FORWARDING_EN
   assign stall_req = id_ex_q.valid && id_ex_q.we && id_ex_q.op == OP_LW &&
                      ((id_use1 && id_rs1 == id_ex_q.rd) || (id_use2 && id_rs2 == id_ex_q.rd));
`else
   logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   assign ex_hit1   = id_ex_q.valid && id_ex_q.we && id_ex_q.rd == id_rs1;
   assign ex_hit2   = id_ex_q.valid && id_ex_q.we && id_ex_q.rd == id_rs2;
   assign mem_hit1  = ex_mem_q.valid && ex_mem_q.we && ex_mem_q.rd == id_rs1;
   assign mem_hit2  = ex_mem_q.valid && ex_mem_q.we && ex_mem_q.rd == id_rs2;
   assign stall_req = (id_use1 && id_rs1 != 5'd0 && (ex_hit1 || mem_hit1)) ||
                      (id_use2 && id_rs2 != 5'd0 && (ex_hit2 || mem_hit2));
`endif

   // ---------------- EX ----------------
   logic [31:0] ex_a, ex_b, ex_result, ex_target;
   logic        ex_taken;

`ifdef FORWARDING_EN
   // EX/MEM is the younger producer, so it wins over MEM/WB.
   assign ex_a = (ex_mem_q.valid && ex_mem_q.we && ex_mem_q.rd == id_ex_q.rs1) ? ex_mem_q.result :
                 (rf_we && mem_wb_q.rd == id_ex_q.rs1) ? mem_wb_q.wdata : id_ex_q.a;
   assign ex_b = (ex_mem_q.valid && ex_mem_q.we && ex_mem_q.rd == id_ex_q.rs2) ? ex_mem_q.result :
                 (rf_we && mem_wb_q.rd == id_ex_q.rs2) ? mem_wb_q.wdata : id_ex_q.b;
`else
   assign ex_a = id_ex_q.a;
   assign ex_b = id_ex_q.b;
`endif

   assign ex_target = id_ex_q.pc + id_ex_q.imm;

   always_comb begin
      ex_result = '0;
      ex_taken  = 1'b0;
      case (id_ex_q.op)
         OP_ADD:                  ex_result = ex_a + ex_b;
         OP_SUB:                  ex_result = ex_a - ex_b;
         OP_AND:                  ex_result = ex_a & ex_b;
         OP_OR:                   ex_result = ex_a | ex_b;
         OP_SLT:                  ex_result = {31'd0, $signed(ex_a) < $signed(ex_b)};
         OP_ADDI, OP_LW, OP_SW:   ex_result = ex_a + id_ex_q.imm;
         OP_ANDI:                 ex_result = ex_a & id_ex_q.imm;
         OP_ORI:                  ex_result = ex_a | id_ex_q.imm;
         OP_BEQ:                  ex_taken  = (ex_a == ex_b);
         OP_BNE:                  ex_taken  = (ex_a != ex_b);
         OP_JAL: begin
            ex_result = id_ex_q.pc + 32'd4;
            ex_taken  = 1'b1;
         end
         OP_LUI:                  ex_result = id_ex_q.imm;
         default: ;
      endcase
   end

   assign flush_o = id_ex_q.valid & ex_taken;
   assign stall_o = stall_req & ~flush_o;

   // ---------------- pipeline registers ----------------
   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         if_id_q  <= '0;
         id_ex_q  <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else begin
         if (flush_o)       pc_q <= ex_target;
         else if (!stall_o) pc_q <= pc_q + 32'd4;

         if (flush_o) begin
            if_id_q <= '0;
         end else if (!stall_o) begin
            if_id_q.valid <= 1'b1;
            if_id_q.pc    <= pc_q;
            if_id_q.instr <= imem_data_i;
         end

         if (flush_o || stall_o) begin
            id_ex_q <= '0;
         end else begin
            id_ex_q.valid <= if_id_q.valid;
            id_ex_q.pc    <= if_id_q.pc;
            id_ex_q.op    <= id_op;
            id_ex_q.rd    <= id_rd;
            id_ex_q.we    <= if_id_q.valid & id_writes & (id_rd != 5'd0);
`ifdef FORWARDING_EN
            id_ex_q.rs1   <= id_rs1;
            id_ex_q.rs2   <= id_rs2;
`endif
            id_ex_q.a     <= id_a;
            id_ex_q.b     <= id_b;
            id_ex_q.imm   <= id_imm;
         end

         ex_mem_q.valid  <= id_ex_q.valid;
         ex_mem_q.pc     <= id_ex_q.pc;
         ex_mem_q.rd     <= id_ex_q.rd;
         ex_mem_q.we     <= id_ex_q.we;
         ex_mem_q.re     <= id_ex_q.valid && id_ex_q.op == OP_LW;
         ex_mem_q.st     <= id_ex_q.valid && id_ex_q.op == OP_SW;
         ex_mem_q.result <= ex_result;
         ex_mem_q.sdata  <= ex_b;

         mem_wb_q.valid <= ex_mem_q.valid;
         mem_wb_q.pc    <= ex_mem_q.pc;
         mem_wb_q.rd    <= ex_mem_q.rd;
         mem_wb_q.we    <= ex_mem_q.we;
         mem_wb_q.wdata <= ex_mem_q.re ? dmem_rdata_i : ex_mem_q.result;
      end
   end

   // NOTE: the register file is reset on purpose; reset must leave every x-register reading zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (rf_we) begin
         regs[mem_wb_q.rd] <= mem_wb_q.wdata;
      end
   end

   assign imem_addr_o    = pc_q;
   assign dmem_addr_o    = ex_mem_q.result;
   assign dmem_wdata_o   = ex_mem_q.sdata;
   assign dmem_we_o      = ex_mem_q.valid & ex_mem_q.st;
   assign dmem_re_o      = ex_mem_q.valid & ex_mem_q.re;
   assign retire_valid_o = mem_wb_q.valid;
   assign retire_pc_o    = mem_wb_q.pc;
   assign retire_we_o    = mem_wb_q.we;
   assign retire_rd_o    = mem_wb_q.rd;
   assign retire_wdata_o = mem_wb_q.wdata;

endmodule

// File: tb/tb_risc_v_pipelined_core.sv
// Scoreboard bench for risc_v_pipelined_core: an instruction-level model predicts retires and stores.
// Cycle-count expectations follow the FORWARDING_EN define used for the build.
module tb_risc_v_pipelined_core;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FORWARDING_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr_o, imem_data_i;
   logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
   logic        dmem_we_o, dmem_re_o;
   logic        retire_valid_o, retire_we_o;
   logic [31:0] retire_pc_o, retire_wdata_o;
   logic [4:0]  retire_rd_o;
   logic        stall_o, flush_o;

   risc_v_pipelined_core #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_we_o(dmem_we_o),
      .dmem_re_o(dmem_re_o), .dmem_rdata_i(dmem_rdata_i),
      .retire_valid_o(retire_valid_o), .retire_pc_o(retire_pc_o), .retire_we_o(retire_we_o),
      .retire_rd_o(retire_rd_o), .retire_wdata_o(retire_wdata_o),
      .stall_o(stall_o), .flush_o(flush_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic we; logic [4:0] rd; logic [31:0] wdata; } ret_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

   int          checks = 0, failures = 0;
   int          cyc = 0, rel_cyc = 0, stall_cnt = 0, flush_cnt = 0;
   logic        mon_en = 1'b0;
   logic [31:0] prog [256];
   int          prog_len = 0;
   logic [31:0] dmem [64];
   logic [31:0] mdm  [64];
   logic [31:0] mr   [32];
   ret_t        exp_q [$];
   st_t         st_q  [$];
   int          ret_cyc [$];
   logic [31:0] fetch_idx;

   always @(posedge clk) cyc++;

   always_comb begin
      fetch_idx   = (imem_addr_o - RESET_PC) >> 2;
      imem_data_i = NOP;
      if (fetch_idx < 32'(prog_len)) imem_data_i = prog[fetch_idx[7:0]];
   end

   assign dmem_rdata_i = dmem[dmem_addr_o[7:2]];
   always @(posedge clk) if (dmem_we_o) dmem[dmem_addr_o[7:2]] <= dmem_wdata_o;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int rc(input int i);
      return (i < ret_cyc.size()) ? ret_cyc[i] : -1000;
   endfunction

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      logic [11:0] im;
      im = imm[11:0];
      return {im, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, rs1);
      logic [11:0] im;
      im = imm[11:0];
      return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
      logic [12:0] im;
      im = imm[12:0];
      return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
      logic [20:0] im;
      im = imm[20:0];
      return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
   endfunction

   task automatic emit(input logic [31:0] ins);
      prog[prog_len] = ins;
      prog_len++;
   endtask

   // ---------------- instruction-level reference model ----------------
   task automatic run_model();
      logic [31:0] pc, ins, a, b, val, npc, addr, immi, imms, immb, immj;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        wr;
      pc = RESET_PC;
      for (int n = 0; n < 1000 && ((pc - RESET_PC) >> 2) < 32'(prog_len); n++) begin
         ins  = prog[8'((pc - RESET_PC) >> 2)];
         rd   = ins[11:7];
         f3   = ins[14:12];
         f7   = ins[31:25];
         a    = mr[ins[19:15]];
         b    = mr[ins[24:20]];
         immi = 32'($signed(ins[31:20]));
         imms = 32'($signed({ins[31:25], ins[11:7]}));
         immb = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         immj = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         npc  = pc + 4;
         wr   = 1'b0;
         val  = 32'd0;
         case (ins[6:0])
            7'h33: begin
               if (f7 == 7'h00 && f3 == 3'd0) begin val = a + b; wr = 1'b1; end
               if (f7 == 7'h20 && f3 == 3'd0) begin val = a - b; wr = 1'b1; end
               if (f7 == 7'h00 && f3 == 3'd7) begin val = a & b; wr = 1'b1; end
               if (f7 == 7'h00 && f3 == 3'd6) begin val = a | b; wr = 1'b1; end
               if (f7 == 7'h00 && f3 == 3'd2) begin val = ($signed(a) < $signed(b)) ? 1 : 0; wr = 1'b1; end
            end
            7'h13: begin
               if (f3 == 3'd0) begin val = a + immi; wr = 1'b1; end
               if (f3 == 3'd7) begin val = a & immi; wr = 1'b1; end
               if (f3 == 3'd6) begin val = a | immi; wr = 1'b1; end
            end
            7'h03: if (f3 == 3'd2) begin
               addr = a + immi;
               val  = mdm[addr[7:2]];
               wr   = 1'b1;
            end
            7'h23: if (f3 == 3'd2) begin
               addr = a + imms;
               st_q.push_back('{addr, b});
               mdm[addr[7:2]] = b;
            end
            7'h63: begin
               if (f3 == 3'd0 && a == b) npc = pc + immb;
               if (f3 == 3'd1 && a != b) npc = pc + immb;
            end
            7'h6f: begin val = pc + 4; wr = 1'b1; npc = pc + immj; end
            7'h37: begin val = {ins[31:12], 12'h000}; wr = 1'b1; end
            default: ;
         endcase
         if (rd == 5'd0) wr = 1'b0;
         if (wr) mr[rd] = val;
         exp_q.push_back('{pc, wr, rd, val});
         pc = npc;
      end
   endtask

   // ---------------- monitor ----------------
   ret_t mon_r;
   st_t  mon_s;
   always @(negedge clk) begin
      if (mon_en && reset) begin
         if (stall_o) stall_cnt++;
         if (flush_o) flush_cnt++;
         if (retire_valid_o && exp_q.size() > 0) begin
            mon_r = exp_q.pop_front();
            check("retire_pc", retire_pc_o, mon_r.pc);
            check("retire_we", {31'd0, retire_we_o}, {31'd0, mon_r.we});
            if (mon_r.we) begin
               check("retire_rd", {27'd0, retire_rd_o}, {27'd0, mon_r.rd});
               check("retire_wdata", retire_wdata_o, mon_r.wdata);
            end
            ret_cyc.push_back(cyc);
         end
         if (dmem_we_o) begin
            if (st_q.size() > 0) begin
               mon_s = st_q.pop_front();
               check("store_addr", dmem_addr_o, mon_s.addr);
               check("store_data", dmem_wdata_o, mon_s.data);
            end else begin
               check("unexpected_store_we", {31'd0, dmem_we_o}, 32'd0);
            end
         end
      end
   end

   // ---------------- one program run ----------------
   task automatic run_test(input string tag);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b0;
      exp_q.delete(); st_q.delete(); ret_cyc.delete();
      stall_cnt = 0;
      flush_cnt = 0;
      for (int k = 0; k < 32; k++) mr[k] = '0;
      for (int k = 0; k < 64; k++) begin
         dmem[k] = $urandom;
         mdm[k]  = dmem[k];
      end
      run_model();
      repeat (3) begin
         @(negedge clk);
         check({tag, ".rst_imem_addr"}, imem_addr_o, RESET_PC);
         check({tag, ".rst_retire_valid"}, {31'd0, retire_valid_o}, 32'd0);
         check({tag, ".rst_dmem_we"}, {31'd0, dmem_we_o}, 32'd0);
         check({tag, ".rst_stall_flush"}, {30'd0, stall_o, flush_o}, 32'd0);
      end
      @(negedge clk);
      reset   = 1'b1;
      rel_cyc = cyc;
      mon_en  = 1'b1;
      for (int c = 0; c < 2000 && (exp_q.size() != 0 || st_q.size() != 0); c++) @(negedge clk);
      check({tag, ".drain"}, 32'(exp_q.size() + st_q.size()), 32'd0);
      repeat (6) @(negedge clk);
      check({tag, ".first_retire_latency"}, 32'(rc(0) - rel_cyc), 32'd4);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rnd;
      int          len, kind;
      logic [4:0]  rd, rs1, rs2;
      reset = 1'b0;

      // adjacent dependency
      prog_len = 0;
      emit(enc_i(5, 0, 3'd0, 1, 7'h13));
      emit(enc_r(7'h00, 1, 1, 3'd0, 2));
      run_test("adj");
      check("adj.retire_gap", 32'(rc(1) - rc(0)), (FWD != 0) ? 32'd1 : 32'd3);
      check("adj.stalls", 32'(stall_cnt), (FWD != 0) ? 32'd0 : 32'd2);

      // store then load-use
      prog_len = 0;
      emit(enc_i(7, 0, 3'd0, 1, 7'h13));
      emit(enc_s(8, 1, 0));
      emit(enc_i(8, 0, 3'd2, 3, 7'h03));
      emit(enc_r(7'h00, 3, 3, 3'd0, 4));
      run_test("ldu");
      check("ldu.stalls", 32'(stall_cnt), (FWD != 0) ? 32'd1 : 32'd4);

      // taken branch squashes two younger instructions
      prog_len = 0;
      emit(enc_b(12, 0, 0, 3'd0));
      emit(enc_i(1, 0, 3'd0, 1, 7'h13));
      emit(enc_i(2, 0, 3'd0, 2, 7'h13));
      emit(enc_i(3, 0, 3'd0, 3, 7'h13));
      run_test("beq");
      check("beq.flushes", 32'(flush_cnt), 32'd1);
      check("beq.retire_gap", 32'(rc(1) - rc(0)), 32'd3);

      // not-taken branch runs sequentially
      prog_len = 0;
      emit(enc_b(12, 0, 0, 3'd1));
      emit(enc_i(1, 0, 3'd0, 1, 7'h13));
      emit(enc_i(2, 0, 3'd0, 2, 7'h13));
      run_test("bne");
      check("bne.flushes", 32'(flush_cnt), 32'd0);
      check("bne.retire_gap", 32'(rc(1) - rc(0)), 32'd1);

      // x0 writes and jal link
      prog_len = 0;
      emit(enc_i(9, 0, 3'd0, 0, 7'h13));
      emit(enc_r(7'h00, 0, 0, 3'd0, 5));
      emit(enc_j(8, 6));
      emit(enc_i(1, 0, 3'd0, 7, 7'h13));
      emit(enc_i(2, 0, 3'd0, 8, 7'h13));
      run_test("jal");
      check("jal.flushes", 32'(flush_cnt), 32'd1);
      check("jal.retire_gap", 32'(rc(3) - rc(2)), 32'd3);

      // reset while a store sits in MEM
      prog_len = 0;
      emit(enc_i(5, 0, 3'd0, 1, 7'h13));
      emit(enc_s(4, 1, 0));
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b0;
      for (int k = 0; k < 64; k++) dmem[k] = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 20 && !dmem_we_o; c++) @(negedge clk);
      check("mid.store_seen", {31'd0, dmem_we_o}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("mid.dmem_we", {31'd0, dmem_we_o}, 32'd0);
      check("mid.imem_addr", imem_addr_o, RESET_PC);
      check("mid.retire_valid", {31'd0, retire_valid_o}, 32'd0);
      @(posedge clk);
      #1 check("mid.no_write", dmem[1], 32'd0);
      prog_len = 0;
      emit(enc_r(7'h00, 1, 1, 3'd0, 2));
      emit(enc_s(0, 1, 0));
      run_test("mid_after");

      // random programs, forward control flow only
      for (int t = 0; t < 20; t++) begin
         prog_len = 0;
         len = $urandom_range(20, 40);
         for (int i = 0; i < len; i++) begin
            kind = $urandom_range(0, 13);
            rd   = 5'($urandom_range(0, 7));
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            case (kind)
               0:  emit(enc_r(7'h00, rs2, rs1, 3'd0, rd));
               1:  emit(enc_r(7'h20, rs2, rs1, 3'd0, rd));
               2:  emit(enc_r(7'h00, rs2, rs1, 3'd7, rd));
               3:  emit(enc_r(7'h00, rs2, rs1, 3'd6, rd));
               4:  emit(enc_r(7'h00, rs2, rs1, 3'd2, rd));
               5:  emit(enc_i($urandom_range(0, 4095) - 2048, rs1, 3'd0, rd, 7'h13));
               6:  emit(enc_i($urandom_range(0, 4095) - 2048, rs1, 3'd7, rd, 7'h13));
               7:  emit(enc_i($urandom_range(0, 4095) - 2048, rs1, 3'd6, rd, 7'h13));
               8:  emit(enc_i(4 * $urandom_range(0, 63), 0, 3'd2, rd, 7'h03));
               9:  emit(enc_s(4 * $urandom_range(0, 63), rs2, 0));
               10: emit(enc_b(4 * $urandom_range(1, 4), rs2, rs1, 3'($urandom_range(0, 1))));
               11: emit(enc_j(4 * $urandom_range(1, 4), rd));
               12: begin
                  rnd = $urandom;
                  emit({rnd[31:12], rd, 7'h37});
               end
               default: begin
                  rnd = $urandom;
                  emit({rnd[31:7], 7'h0f});
               end
            endcase
         end
         run_test($sformatf("rand%0d", t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
